maze_player_ctrl: RTL
=====================

Name: maze_player_ctrl

Overview:
- Player-movement controller; initiator side of the maze wall-lookup interface.
- Drives a tile (row, col) query into the level wall ROM, reads back the 4-bit wall code and decides whether a requested move is legal.
- Steps the player sprite pixel-by-pixel across one tile on a pixel-rate tick.
- Reports sprite position, current tile, move count and goal status to the renderer and game FSM.

Parameters:
- ROW_W, 5, width of row index.
- COL_W, 5, width of column index.
- TILE_PX, 32, tile size in pixels (power of two, 2..64).
- NUM_ROWS, 25, maze rows.
- NUM_COLS, 25, maze columns.
- START_ROW, 1, reset/restart row.
- START_COL, 1, reset/restart column.
- GOAL_ROW, 23, goal row.
- GOAL_COL, 23, goal column.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_up  in  1  move-up request (level)
- btn_down  in  1  move-down request (level)
- btn_left  in  1  move-left request (level)
- btn_right  in  1  move-right request (level)
- tick  in  1  pixel-step enable, 1-cycle pulse
- restart  in  1  synchronous return to start
- q_row  out  ROW_W  wall-ROM query row
- q_col  out  COL_W  wall-ROM query column
- walls  in  4  ROM response {T,B,L,R}, combinational from q_row/q_col
- cur_row  out  ROW_W  current tile row
- cur_col  out  COL_W  current tile column
- player_x  out  10  sprite left pixel
- player_y  out  10  sprite top pixel
- moving  out  1  high while stepping between tiles
- bumped  out  1  1-cycle pulse: move refused
- at_goal  out  1  sticky: goal tile reached
- move_count  out  16  completed moves, saturating

Behaviour:
- Wall bit order is {T,B,L,R}, bits 3..0. A set bit means the corresponding side of the current tile is blocked. Only the current tile's walls are consulted.
- q_row/q_col are registered and always equal cur_row/cur_col.
- Reset (rst_n low, asynchronous) sets:
  - cur_row/cur_col = START_ROW/START_COL
  - player_x = START_COL*TILE_PX, player_y = START_ROW*TILE_PX
  - moving = 0, bumped = 0, move_count = 0
  - at_goal = (START == GOAL)
  - armed = 1, state IDLE
- States: IDLE, LOOKUP, DECIDE, STEP.
- IDLE:
  - If at_goal is high, buttons are ignored.
  - Otherwise, if armed and any button is high, latch the direction with priority up > down > left > right, clear armed, and go to LOOKUP.
  - armed re-sets only in a cycle where all four buttons are low. A held button therefore produces exactly one request.
- LOOKUP: one wait cycle for ROM settle, then go to DECIDE.
- DECIDE: sample walls. The move is blocked if any of the following holds:
  - the wall bit for the latched direction is set;
  - up with row == 0;
  - down with row == NUM_ROWS-1;
  - left with col == 0;
  - right with col == NUM_COLS-1.
- On a blocked move: bumped = 1 in the next cycle for exactly one cycle; return to IDLE.
- On a legal move: moving = 1 from the next cycle; go to STEP.
- Latency: request accepted in IDLE cycle N → walls sampled in cycle N+2 → bumped or moving visible in cycle N+3.
- STEP:
  - Each tick advances player_x or player_y by ±1 pixel; a pixel counter runs 0..TILE_PX-1.
  - tick is ignored outside STEP.
  - On the TILE_PX-th tick: update cur_row/cur_col (and q_row/q_col) in the same cycle, increment move_count (saturates at 16'hFFFF), clear moving, set at_goal if the new tile is the goal, go to IDLE.
  - player_x/player_y always equal tile*TILE_PX when not moving.
  - Buttons are ignored during STEP, but armed still re-sets on release.
- restart has highest priority; it is synchronous and valid from any state, including mid-STEP. On the next edge it restores all reset values.
- rst_n asserted mid-STEP returns immediately to reset values; a partial pixel offset is discarded.
- Position arithmetic is unsigned 10-bit. Parameters guarantee no overflow: NUM_COLS*TILE_PX ≤ 1024.

Test Plan:
- Stub ROM: (1,1) = 4'b1110, all others 4'b0000. Hold btn_right, supply 32 ticks → moving high for the step; player_x 32→64 monotonically; cur_col = 2, move_count = 1, bumped never set.
- At (1,1), pulse btn_up → bumped high exactly once at cycle N+3; player_y stays 32; move_count unchanged.
- Hold btn_right for 200 cycles with continuous ticks → exactly one move (cur_col = 2); release and press again → second move (cur_col = 3).
- btn_up and btn_right asserted in the same cycle at (2,2), no walls → up chosen; cur_row = 1.
- Assert restart after 10 ticks of a step → next cycle: cur = (1,1), player_x = 32, moving = 0, move_count = 0.
- GOAL = (1,2); move right from start → at_goal = 1 and move_count = 1; later button presses produce no movement and no bumped pulse.

Source files
------------

// File: rtl/maze_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maze_player_ctrl
// Purpose  : Player-movement controller for the maze game. It queries the
//            level wall ROM with the current tile and decides whether a
//            requested move is legal. It then walks the sprite one pixel per
//            tick across a tile and reports position, move count and goal
//            status.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            btn_up/down/left/right - level move requests
//            tick               - pixel-step enable (1-cycle pulse)
//            restart            - synchronous return to start position
//            q_row, q_col       - wall-ROM query (registered, = current tile)
//            walls              - ROM response {T,B,L,R}, combinational
//            cur_row, cur_col   - current tile
//            player_x, player_y - sprite top-left pixel
//            moving             - high while stepping between tiles
//            bumped             - 1-cycle pulse when a move is refused
//            at_goal            - sticky goal-reached flag
//            move_count         - completed moves, saturating
// Revision : 1.0 - initial release
// ============================================================================
module maze_player_ctrl #(
   parameter int ROW_W     = 5,
   parameter int COL_W     = 5,
   parameter int TILE_PX   = 32,
   parameter int NUM_ROWS  = 25,
   parameter int NUM_COLS  = 25,
   parameter int START_ROW = 1,
   parameter int START_COL = 1,
   parameter int GOAL_ROW  = 23,
   parameter int GOAL_COL  = 23
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             tick,
   input  logic             restart,
   output logic [ROW_W-1:0] q_row,
   output logic [COL_W-1:0] q_col,
   input  logic [3:0]       walls,
   output logic [ROW_W-1:0] cur_row,
   output logic [COL_W-1:0] cur_col,
   output logic [9:0]       player_x,
   output logic [9:0]       player_y,
   output logic             moving,
   output logic             bumped,
   output logic             at_goal,
   output logic [15:0]      move_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_DECIDE = 2'd2,
      S_STEP   = 2'd3
   } state_t;

   localparam logic [1:0] C_DIR_UP    = 2'd0;
   localparam logic [1:0] C_DIR_DOWN  = 2'd1;
   localparam logic [1:0] C_DIR_LEFT  = 2'd2;
   localparam logic [1:0] C_DIR_RIGHT = 2'd3;

   localparam int                C_PW        = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
   localparam logic [C_PW-1:0]   C_PIX_LAST  = C_PW'(TILE_PX - 1);
   localparam logic [ROW_W-1:0]  C_START_ROW = ROW_W'(START_ROW);
   localparam logic [COL_W-1:0]  C_START_COL = COL_W'(START_COL);
   localparam logic [ROW_W-1:0]  C_GOAL_ROW  = ROW_W'(GOAL_ROW);
   localparam logic [COL_W-1:0]  C_GOAL_COL  = COL_W'(GOAL_COL);
   localparam logic [ROW_W-1:0]  C_LAST_ROW  = ROW_W'(NUM_ROWS - 1);
   localparam logic [COL_W-1:0]  C_LAST_COL  = COL_W'(NUM_COLS - 1);
   localparam logic [9:0]        C_START_X   = 10'(START_COL * TILE_PX);
   localparam logic [9:0]        C_START_Y   = 10'(START_ROW * TILE_PX);
   localparam logic              C_START_GOAL = (START_ROW == GOAL_ROW) && (START_COL == GOAL_COL);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_dir;
   logic              r_armed;
   logic [ROW_W-1:0]  r_cur_row;
   logic [COL_W-1:0]  r_cur_col;
   logic [ROW_W-1:0]  r_q_row;
   logic [COL_W-1:0]  r_q_col;
   logic [9:0]        r_px;
   logic [9:0]        r_py;
   logic [C_PW-1:0]   r_pix_cnt;
   logic              r_moving;
   logic              r_bumped;
   logic              r_at_goal;
   logic [15:0]       r_move_count;

   logic              w_any_btn;
   logic [1:0]        w_dir_sel;
   logic              w_wall_bit;
   logic              w_edge_block;
   logic              w_blocked;
   logic              w_accept;
   logic              w_last_tick;
   logic [ROW_W-1:0]  w_next_row;
   logic [COL_W-1:0]  w_next_col;

   assign w_any_btn = btn_up | btn_down | btn_left | btn_right;
   assign w_blocked = w_wall_bit | w_edge_block;

   // Direction decode, wall/edge test and destination tile for the latched move
   always_comb begin
      w_dir_sel    = C_DIR_RIGHT;
      w_wall_bit   = 1'b0;
      w_edge_block = 1'b0;
      w_next_row   = r_cur_row;
      w_next_col   = r_cur_col;
      if (btn_up)        w_dir_sel = C_DIR_UP;
      else if (btn_down) w_dir_sel = C_DIR_DOWN;
      else if (btn_left) w_dir_sel = C_DIR_LEFT;
      case (r_dir)
         C_DIR_UP: begin
            w_wall_bit   = walls[3];
            w_edge_block = (r_cur_row == '0);
            w_next_row   = r_cur_row - ROW_W'(1);
         end
         C_DIR_DOWN: begin
            w_wall_bit   = walls[2];
            w_edge_block = (r_cur_row == C_LAST_ROW);
            w_next_row   = r_cur_row + ROW_W'(1);
         end
         C_DIR_LEFT: begin
            w_wall_bit   = walls[1];
            w_edge_block = (r_cur_col == '0);
            w_next_col   = r_cur_col - COL_W'(1);
         end
         default: begin
            w_wall_bit   = walls[0];
            w_edge_block = (r_cur_col == C_LAST_COL);
            w_next_col   = r_cur_col + COL_W'(1);
         end
      endcase
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last_tick = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_at_goal && r_armed && w_any_btn) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: w_state_nxt = S_DECIDE;
         S_DECIDE: w_state_nxt = w_blocked ? S_IDLE : S_STEP;
         S_STEP: begin
            if (tick && (r_pix_cnt == C_PIX_LAST)) begin
               w_last_tick = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (restart) begin
         w_state_nxt = S_IDLE;
         w_accept    = 1'b0;
         w_last_tick = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath; restart restores exactly the asynchronous reset image
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir        <= C_DIR_UP;
         r_armed      <= 1'b1;
         r_cur_row    <= C_START_ROW;
         r_cur_col    <= C_START_COL;
         r_q_row      <= C_START_ROW;
         r_q_col      <= C_START_COL;
         r_px         <= C_START_X;
         r_py         <= C_START_Y;
         r_pix_cnt    <= '0;
         r_moving     <= 1'b0;
         r_bumped     <= 1'b0;
         r_at_goal    <= C_START_GOAL;
         r_move_count <= 16'd0;
      end else if (restart) begin
         r_dir        <= C_DIR_UP;
         r_armed      <= 1'b1;
         r_cur_row    <= C_START_ROW;
         r_cur_col    <= C_START_COL;
         r_q_row      <= C_START_ROW;
         r_q_col      <= C_START_COL;
         r_px         <= C_START_X;
         r_py         <= C_START_Y;
         r_pix_cnt    <= '0;
         r_moving     <= 1'b0;
         r_bumped     <= 1'b0;
         r_at_goal    <= C_START_GOAL;
         r_move_count <= 16'd0;
      end else begin
         r_bumped <= 1'b0;
         // Re-arming on full release is what makes a held button a single request
         if (!w_any_btn) r_armed <= 1'b1;
         if (w_accept) begin
            r_dir   <= w_dir_sel;
            r_armed <= 1'b0;
         end
         if (r_state == S_DECIDE) begin
            if (w_blocked) begin
               r_bumped <= 1'b1;
            end else begin
               r_moving  <= 1'b1;
               r_pix_cnt <= '0;
            end
         end
         if ((r_state == S_STEP) && tick) begin
            r_pix_cnt <= r_pix_cnt + C_PW'(1);
            case (r_dir)
               C_DIR_UP:    r_py <= r_py - 10'd1;
               C_DIR_DOWN:  r_py <= r_py + 10'd1;
               C_DIR_LEFT:  r_px <= r_px - 10'd1;
               default:     r_px <= r_px + 10'd1;
            endcase
            if (w_last_tick) begin
               r_cur_row <= w_next_row;
               r_cur_col <= w_next_col;
               r_q_row   <= w_next_row;
               r_q_col   <= w_next_col;
               r_moving  <= 1'b0;
               if (r_move_count != 16'hFFFF) r_move_count <= r_move_count + 16'd1;
               if ((w_next_row == C_GOAL_ROW) && (w_next_col == C_GOAL_COL)) r_at_goal <= 1'b1;
            end
         end
      end
   end

   assign q_row      = r_q_row;
   assign q_col      = r_q_col;
   assign cur_row    = r_cur_row;
   assign cur_col    = r_cur_col;
   assign player_x   = r_px;
   assign player_y   = r_py;
   assign moving     = r_moving;
   assign bumped     = r_bumped;
   assign at_goal    = r_at_goal;
   assign move_count = r_move_count;

endmodule
`default_nettype wire
